end_screen: RTL and testbench
=============================

END_SCREEN -- requirements
Module: end_screen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  STAR_COUNT 12 -- stars drawn, legal 0..16, first N entries of package star table
  STAR_SIZE 20 -- star bounding size in pixels, even
  LETTER_W 60 / LETTER_H 100 / LETTER_GAP 20 -- glyph cell width, height, spacing
  TEXT_Y 180 -- top row of message
  REVEAL_STEP 4 -- message rows uncovered per frame
  RGB_W 5 -- colour word width
  WIN_COLOR 5'b11111 / LOSE_COLOR 5'b11000 -- message colours
REQ-002 Ports (name direction width meaning), one per line:
  clk  in  1  pixel clock
  reset_n  in  1  asynchronous active-low reset
  video_on  in  1  active display area
  pixel_x  in  11  current column
  pixel_y  in  11  current row
  frame_tick  in  1  one-clk pulse at start of each frame
  show  in  1  level; screen requested
  mode  in  1  0 = "WIN", 1 = "LOSE"
  vga_rgb  out  RGB_W  registered pixel colour
  active  out  1  state != IDLE
  done  out  1  one-clk pulse when reveal completes

Function
REQ-003 States IDLE, REVEAL, HOLD; IDLE->REVEAL on show=1; REVEAL->HOLD when rows_shown reaches LETTER_H; REVEAL/HOLD->IDLE in the cycle after show=0.
REQ-004 mode latched into mode_q on the IDLE->REVEAL transition only; mode changes in REVEAL/HOLD ignored.
REQ-005 rows_shown (7-bit min) cleared in IDLE; in REVEAL += REVEAL_STEP per frame_tick, saturating at LETTER_H.
REQ-006 done = 1 for exactly the clk of REVEAL->HOLD transition; 0 otherwise.
REQ-007 frame_cnt (8 bit) increments on every frame_tick in any state, wraps 255->0; twinkle phase = frame_cnt[5:3].
REQ-008 vga_rgb latency exactly 1 clk: value at edge n+1 reflects inputs at edge n.
REQ-009 vga_rgb = 0 when video_on=0 or state=IDLE.
REQ-010 Star pixel: dx,dy = |pixel - centre| both < STAR_SIZE/2 and (dx+dy < STAR_SIZE/2 or ((dx < STAR_SIZE/4 or dy < STAR_SIZE/4) and dx+dy < STAR_SIZE)).
REQ-011 Star i colour: 5'b11110 if (i+phase) mod 8 < 6, else 5'b10100.
REQ-012 Message horizontally centred on 640: N letters (3 or 4), x_start = (640 - N*LETTER_W - (N-1)*LETTER_GAP)/2.
REQ-013 Message pixel drawn only if glyph hit and (pixel_y - TEXT_Y) < rows_shown; colour WIN_COLOR or LOSE_COLOR per mode_q.
REQ-014 Priority: star > message > black; stars shown in REVEAL and HOLD.
REQ-015 show and frame_tick in same clk while leaving: show=0 wins, rows_shown not advanced.
REQ-016 All coordinate arithmetic unsigned 11 bit; no subtraction evaluated below zero (compare before subtract).

Reset
REQ-017 reset_n low asynchronously forces state=IDLE, rows_shown=0, frame_cnt=0, mode_q=0, vga_rgb=0, active=0, done=0.
REQ-018 Reset release mid-frame: first output follows REQ-009; show already high enters REVEAL on the first clk after release.

Structure
REQ-019 Package end_screen_pkg holds: state enum, colour constants, 16-entry star x/y table, glyph id constants (W,I,N,L,O,S,E), screen 640x480 constants.
REQ-020 One combinational sub-module end_screen_glyph (inputs glyph id, local x, local y; output hit), stroke width 12.
REQ-021 end_screen is single-clock; only the REQ-017 registers plus output register.

Verification
REQ-022 reset_n low, then show=1, mode=0 -> active=1 next clk; after 25 frame_ticks done pulses once, state HOLD.
REQ-023 HOLD, mode=0, pixel (290,185) in I top bar -> vga_rgb=5'b11111 one clk later; video_on=0 -> 0.
REQ-024 REVEAL after 2 frame_ticks (rows_shown=8): pixel row 187 text -> colour, row 188 -> 0.
REQ-025 Star 0 centre (80,60), frame_cnt=48 (phase 6) -> 5'b10100; frame_cnt=0 -> 5'b11110.
REQ-026 mode=1 at show rise, mode toggled to 0 during HOLD -> "LOSE" in 5'b11000 persists; show=0 -> black and active=0 next clk.
REQ-027 reset_n asserted mid-REVEAL -> all outputs 0 immediately, without a clk edge.

Source files
------------

// File: rtl/end_screen_pkg.sv
// Shared constants for the end-of-game screen: FSM encodings, colours,
// the star position table, glyph identifiers and screen geometry.
package end_screen_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REVEAL = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [4:0] STAR_BRIGHT = 5'b11110;
    localparam logic [4:0] STAR_DIM    = 5'b10100;

    localparam logic [2:0] GLYPH_W = 3'd0;
    localparam logic [2:0] GLYPH_I = 3'd1;
    localparam logic [2:0] GLYPH_N = 3'd2;
    localparam logic [2:0] GLYPH_L = 3'd3;
    localparam logic [2:0] GLYPH_O = 3'd4;
    localparam logic [2:0] GLYPH_S = 3'd5;
    localparam logic [2:0] GLYPH_E = 3'd6;

    // Star centres are kept clear of the message band so stars never mask text.
    function automatic logic [10:0] star_x(input logic [3:0] idx);
        case (idx)
            4'd0:    return 11'd80;
            4'd1:    return 11'd200;
            4'd2:    return 11'd320;
            4'd3:    return 11'd450;
            4'd4:    return 11'd560;
            4'd5:    return 11'd40;
            4'd6:    return 11'd600;
            4'd7:    return 11'd100;
            4'd8:    return 11'd540;
            4'd9:    return 11'd250;
            4'd10:   return 11'd400;
            4'd11:   return 11'd600;
            4'd12:   return 11'd30;
            4'd13:   return 11'd150;
            4'd14:   return 11'd480;
            4'd15:   return 11'd320;
            default: return 11'd0;
        endcase
    endfunction

    function automatic logic [10:0] star_y(input logic [3:0] idx);
        case (idx)
            4'd0:    return 11'd60;
            4'd1:    return 11'd40;
            4'd2:    return 11'd90;
            4'd3:    return 11'd50;
            4'd4:    return 11'd70;
            4'd5:    return 11'd200;
            4'd6:    return 11'd220;
            4'd7:    return 11'd330;
            4'd8:    return 11'd340;
            4'd9:    return 11'd420;
            4'd10:   return 11'd400;
            4'd11:   return 11'd440;
            4'd12:   return 11'd450;
            4'd13:   return 11'd130;
            4'd14:   return 11'd140;
            4'd15:   return 11'd330;
            default: return 11'd0;
        endcase
    endfunction

    function automatic logic [2:0] letter_glyph(input logic lose, input logic [1:0] pos);
        case ({lose, pos})
            3'b000:  return GLYPH_W;
            3'b001:  return GLYPH_I;
            3'b010:  return GLYPH_N;
            3'b100:  return GLYPH_L;
            3'b101:  return GLYPH_O;
            3'b110:  return GLYPH_S;
            3'b111:  return GLYPH_E;
            default: return GLYPH_W;
        endcase
    endfunction

endpackage

// File: rtl/end_screen_glyph.sv
// Combinational block-letter renderer: reports whether a cell-local
// coordinate lies on a stroke of the selected glyph.
module end_screen_glyph
    import end_screen_pkg::*;
#(
    parameter int CELL_W = 60,
    parameter int CELL_H = 100,
    parameter int STROKE = 12
) (
    input  logic [2:0]  glyph,
    input  logic [10:0] lx,
    input  logic [10:0] ly,
    output logic        hit
);

    logic left, right, top, bot, mid_h, mid_v, upper, diag;
    logic [21:0] prod_a, prod_b, diff;

    // Stroke primitives, then per-glyph composition.
    always_comb begin
        left   = lx < 11'(STROKE);
        right  = lx >= 11'(CELL_W - STROKE);
        top    = ly < 11'(STROKE);
        bot    = ly >= 11'(CELL_H - STROKE);
        mid_h  = (ly >= 11'(CELL_H / 2 - STROKE / 2)) && (ly < 11'(CELL_H / 2 + STROKE / 2));
        mid_v  = (lx >= 11'(CELL_W / 2 - STROKE / 2)) && (lx < 11'(CELL_W / 2 + STROKE / 2));
        upper  = ly < 11'(CELL_H / 2);
        // N diagonal: |x*H - y*W| below the stroke band, ordered to avoid underflow
        prod_a = 22'(lx) * 22'(CELL_H);
        prod_b = 22'(ly) * 22'(CELL_W);
        diff   = (prod_a >= prod_b) ? (prod_a - prod_b) : (prod_b - prod_a);
        diag   = diff < 22'(STROKE * CELL_H);
        case (glyph)
            GLYPH_W: hit = left | right | bot | (mid_v & ~upper);
            GLYPH_I: hit = top | bot | mid_v;
            GLYPH_N: hit = left | right | diag;
            GLYPH_L: hit = left | bot;
            GLYPH_O: hit = left | right | top | bot;
            GLYPH_S: hit = top | bot | mid_h | (left & upper) | (right & ~upper);
            GLYPH_E: hit = left | top | bot | mid_h;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/end_screen.sv
// End-of-game overlay: twinkling star field plus a "WIN"/"LOSE" message
// uncovered top-down a few rows per frame, with a one-clock pixel pipeline.
module end_screen
    import end_screen_pkg::*;
#(
    parameter int STAR_COUNT  = 12,
    parameter int STAR_SIZE   = 20,
    parameter int LETTER_W    = 60,
    parameter int LETTER_H    = 100,
    parameter int LETTER_GAP  = 20,
    parameter int TEXT_Y      = 180,
    parameter int REVEAL_STEP = 4,
    parameter int RGB_W       = 5,
    parameter logic [RGB_W-1:0] WIN_COLOR  = 5'b11111,
    parameter logic [RGB_W-1:0] LOSE_COLOR = 5'b11000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             video_on,
    input  logic [10:0]      pixel_x,
    input  logic [10:0]      pixel_y,
    input  logic             frame_tick,
    input  logic             show,
    input  logic             mode,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             active,
    output logic             done
);

    localparam int X_WIN  = (SCREEN_W - 3 * LETTER_W - 2 * LETTER_GAP) / 2;
    localparam int X_LOSE = (SCREEN_W - 4 * LETTER_W - 3 * LETTER_GAP) / 2;

    logic [1:0]       state;
    logic             mode_q;
    logic [6:0]       rows_shown;
    logic [7:0]       frame_cnt;
    logic [6:0]       rows_step;
    logic [7:0]       rows_sum;
    logic [15:0]      star_vec;
    logic [RGB_W-1:0] star_col;
    logic [RGB_W-1:0] pix;
    logic [2:0]       gid;
    logic [10:0]      lx, ly, lo;
    logic             in_cell, in_rows, glyph_hit;

    function automatic logic star_pixel(input logic [10:0] px, input logic [10:0] py,
                                        input logic [10:0] cx, input logic [10:0] cy);
        logic [10:0] dx, dy;
        logic [11:0] sum;
        dx  = (px >= cx) ? (px - cx) : (cx - px);
        dy  = (py >= cy) ? (py - cy) : (cy - py);
        sum = {1'b0, dx} + {1'b0, dy};
        return (dx < 11'(STAR_SIZE / 2)) && (dy < 11'(STAR_SIZE / 2)) &&
               ((sum < 12'(STAR_SIZE / 2)) ||
                (((dx < 11'(STAR_SIZE / 4)) || (dy < 11'(STAR_SIZE / 4))) && (sum < 12'(STAR_SIZE))));
    endfunction

    function automatic logic [RGB_W-1:0] star_colour(input logic [2:0] idx, input logic [2:0] phase);
        logic [2:0] p;
        p = idx + phase;
        return (p < 3'd6) ? RGB_W'(STAR_BRIGHT) : RGB_W'(STAR_DIM);
    endfunction

    end_screen_glyph #(.CELL_W(LETTER_W), .CELL_H(LETTER_H), .STROKE(12)) u_glyph (
        .glyph (gid),
        .lx    (lx),
        .ly    (ly),
        .hit   (glyph_hit)
    );

    assign active = (state != ST_IDLE);

    // Saturating reveal advance.
    always_comb begin
        rows_sum  = {1'b0, rows_shown} + 8'(REVEAL_STEP);
        rows_step = (rows_sum >= 8'(LETTER_H)) ? 7'(LETTER_H) : rows_sum[6:0];
    end

    // Pixel colour for the current inputs; lowest-index star wins overlaps.
    always_comb begin
        star_col = '0;
        gid      = GLYPH_W;
        lx       = 11'd0;
        lo       = 11'd0;
        in_cell  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            star_vec[i] = (i < STAR_COUNT) &&
                          star_pixel(pixel_x, pixel_y, star_x(4'(i)), star_y(4'(i)));
        end
        for (int i = 15; i >= 0; i--) begin
            star_col = star_vec[i] ? star_colour(3'(i), frame_cnt[5:3]) : star_col;
        end
        for (int k = 0; k < 4; k++) begin
            lo = 11'((mode_q ? X_LOSE : X_WIN) + k * (LETTER_W + LETTER_GAP));
            if ((k < 3 || mode_q) && pixel_x >= lo && pixel_x < lo + 11'(LETTER_W)) begin
                in_cell = 1'b1;
                lx      = pixel_x - lo;
                gid     = letter_glyph(mode_q, 2'(k));
            end else begin
                in_cell = in_cell;
            end
        end
        in_rows = (pixel_y >= 11'(TEXT_Y)) && (pixel_y < 11'(TEXT_Y + LETTER_H));
        ly      = in_rows ? (pixel_y - 11'(TEXT_Y)) : 11'd0;
        if (!video_on || state == ST_IDLE || !show) begin
            pix = '0;
        end else if (star_vec != 16'd0) begin
            pix = star_col;
        end else if (in_cell && in_rows && glyph_hit && ly < {4'd0, rows_shown}) begin
            pix = mode_q ? LOSE_COLOR : WIN_COLOR;
        end else begin
            pix = '0;
        end
    end

    // Screen FSM, reveal progress, frame counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rows_shown <= 7'd0;
            frame_cnt  <= 8'd0;
            mode_q     <= 1'b0;
            vga_rgb    <= '0;
            done       <= 1'b0;
        end else begin
            vga_rgb <= pix;
            done    <= 1'b0;
            if (frame_tick) frame_cnt <= frame_cnt + 8'd1;
            case (state)
                ST_IDLE: begin
                    rows_shown <= 7'd0;
                    if (show) begin
                        state  <= ST_REVEAL;
                        mode_q <= mode;
                    end
                end
                ST_REVEAL: begin
                    if (!show) begin
                        state      <= ST_IDLE;
                        rows_shown <= 7'd0;
                    end else if (frame_tick) begin
                        rows_shown <= rows_step;
                        if (rows_step == 7'(LETTER_H)) begin
                            state <= ST_HOLD;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!show) begin
                        state      <= ST_IDLE;
                        rows_shown <= 7'd0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    rows_shown <= 7'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_end_screen.sv
// Directed self-checking bench for end_screen.
module tb_end_screen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        video_on;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        frame_tick;
    logic        show;
    logic        mode;
    logic [4:0]  vga_rgb;
    logic        active;
    logic        done;

    int checks   = 0;
    int failures = 0;

    end_screen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick),
        .show       (show),
        .mode       (mode),
        .vga_rgb    (vga_rgb),
        .active     (active),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic vo);
        pixel_x  = 11'(x);
        pixel_y  = 11'(y);
        video_on = vo;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; show = 1'b1; mode = 1'b0; frame_tick = 1'b0;
        video_on = 1'b1; pixel_x = 11'd290; pixel_y = 11'd185;
        tick(); tick();
        checks++; if (vga_rgb !== 5'd0) begin $display("FAIL reset_rgb got=%b exp=%b", vga_rgb, 5'd0); failures++; end
        checks++; if (active !== 1'b0) begin $display("FAIL reset_active got=%b exp=0", active); failures++; end
        checks++; if (done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", done); failures++; end
        #3 reset_n = 1'b1;
        tick();
        checks++; if (active !== 1'b1) begin $display("FAIL enter_active got=%b exp=1", active); failures++; end
        checks++; if (vga_rgb !== 5'd0) begin $display("FAIL enter_rgb_idle got=%b exp=0", vga_rgb); failures++; end
    endtask

    task automatic test_reveal_win();
        frame_tick = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (done !== 1'b0) begin $display("FAIL early_done i=%0d got=%b exp=0", i, done); failures++; end
        end
        frame_tick = 1'b0;
        pix(290, 187, 1'b1);
        checks++; if (vga_rgb !== 5'b11111) begin $display("FAIL row187 got=%b exp=11111", vga_rgb); failures++; end
        pix(290, 188, 1'b1);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL row188 got=%b exp=00000", vga_rgb); failures++; end
        frame_tick = 1'b1;
        for (int i = 0; i < 23; i++) begin
            tick();
            checks++;
            if (done !== (i == 22)) begin $display("FAIL done_pulse i=%0d got=%b exp=%b", i, done, (i == 22)); failures++; end
        end
        frame_tick = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL done_single got=%b exp=0", done); failures++; end
        checks++; if (active !== 1'b1) begin $display("FAIL hold_active got=%b exp=1", active); failures++; end
    endtask

    task automatic test_hold_win();
        pix(290, 185, 1'b1);
        checks++; if (vga_rgb !== 5'b11111) begin $display("FAIL i_topbar got=%b exp=11111", vga_rgb); failures++; end
        pix(290, 185, 1'b0);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL video_off got=%b exp=00000", vga_rgb); failures++; end
        pix(275, 200, 1'b1);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL letter_gap got=%b exp=00000", vga_rgb); failures++; end
        pix(215, 250, 1'b1);
        checks++; if (vga_rgb !== 5'b11111) begin $display("FAIL w_left got=%b exp=11111", vga_rgb); failures++; end
        pix(300, 279, 1'b1);
        checks++; if (vga_rgb !== 5'b11111) begin $display("FAIL last_row got=%b exp=11111", vga_rgb); failures++; end
    endtask

    task automatic test_stars();
        frame_tick = 1'b1;
        for (int i = 0; i < 23; i++) begin
            tick();
            checks++; if (done !== 1'b0) begin $display("FAIL hold_no_done i=%0d got=%b exp=0", i, done); failures++; end
        end
        frame_tick = 1'b0;
        pix(80, 60, 1'b1);
        checks++; if (vga_rgb !== 5'b10100) begin $display("FAIL star0_ph6 got=%b exp=10100", vga_rgb); failures++; end
        pix(200, 40, 1'b1);
        checks++; if (vga_rgb !== 5'b10100) begin $display("FAIL star1_ph6 got=%b exp=10100", vga_rgb); failures++; end
        pix(320, 90, 1'b1);
        checks++; if (vga_rgb !== 5'b11110) begin $display("FAIL star2_ph6 got=%b exp=11110", vga_rgb); failures++; end
        pix(89, 60, 1'b1);
        checks++; if (vga_rgb !== 5'b10100) begin $display("FAIL star_dx9 got=%b exp=10100", vga_rgb); failures++; end
        pix(90, 60, 1'b1);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL star_dx10 got=%b exp=00000", vga_rgb); failures++; end
        pix(87, 67, 1'b1);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL star_diag got=%b exp=00000", vga_rgb); failures++; end
        pix(83, 68, 1'b1);
        checks++; if (vga_rgb !== 5'b10100) begin $display("FAIL star_arm got=%b exp=10100", vga_rgb); failures++; end
        pix(30, 450, 1'b1);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL star12_off got=%b exp=00000", vga_rgb); failures++; end
        frame_tick = 1'b1;
        for (int i = 0; i < 208; i++) tick();
        frame_tick = 1'b0;
        pix(80, 60, 1'b1);
        checks++; if (vga_rgb !== 5'b11110) begin $display("FAIL star0_ph0 got=%b exp=11110", vga_rgb); failures++; end
    endtask

    task automatic test_leave();
        show = 1'b0;
        pix(290, 185, 1'b1);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL leave_rgb got=%b exp=00000", vga_rgb); failures++; end
        checks++; if (active !== 1'b0) begin $display("FAIL leave_active got=%b exp=0", active); failures++; end
    endtask

    task automatic test_lose();
        show = 1'b1; mode = 1'b1;
        tick();
        mode = 1'b0;
        frame_tick = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++; if (done !== (i == 24)) begin $display("FAIL lose_done i=%0d got=%b exp=%b", i, done, (i == 24)); failures++; end
        end
        frame_tick = 1'b0;
        pix(175, 250, 1'b1);
        checks++; if (vga_rgb !== 5'b11000) begin $display("FAIL l_left got=%b exp=11000", vga_rgb); failures++; end
        pix(305, 230, 1'b1);
        checks++; if (vga_rgb !== 5'b11000) begin $display("FAIL o_right got=%b exp=11000", vga_rgb); failures++; end
        pix(350, 185, 1'b1);
        checks++; if (vga_rgb !== 5'b11000) begin $display("FAIL s_top got=%b exp=11000", vga_rgb); failures++; end
        pix(440, 230, 1'b1);
        checks++; if (vga_rgb !== 5'b11000) begin $display("FAIL e_mid got=%b exp=11000", vga_rgb); failures++; end
        pix(215, 250, 1'b1);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL lose_no_w got=%b exp=00000", vga_rgb); failures++; end
        pix(290, 185, 1'b1);
        checks++; if (vga_rgb !== 5'b11000) begin $display("FAIL o_top got=%b exp=11000", vga_rgb); failures++; end
        show = 1'b0;
        pix(290, 185, 1'b1);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL lose_leave_rgb got=%b exp=00000", vga_rgb); failures++; end
        checks++; if (active !== 1'b0) begin $display("FAIL lose_leave_active got=%b exp=0", active); failures++; end
    endtask

    task automatic test_back_to_back();
        show = 1'b1; mode = 1'b0;
        tick();
        show = 1'b0; frame_tick = 1'b1;
        tick();
        checks++; if (active !== 1'b0) begin $display("FAIL leave_wins got=%b exp=0", active); failures++; end
        checks++; if (done !== 1'b0) begin $display("FAIL leave_no_done got=%b exp=0", done); failures++; end
        show = 1'b1; frame_tick = 1'b0;
        tick();
        pix(290, 180, 1'b1);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL rows_zero got=%b exp=00000", vga_rgb); failures++; end
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        pix(290, 183, 1'b1);
        checks++; if (vga_rgb !== 5'b11111) begin $display("FAIL row183 got=%b exp=11111", vga_rgb); failures++; end
        pix(290, 184, 1'b1);
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL row184 got=%b exp=00000", vga_rgb); failures++; end
    endtask

    task automatic test_async_reset();
        pix(290, 183, 1'b1);
        checks++; if (vga_rgb !== 5'b11111) begin $display("FAIL pre_reset_rgb got=%b exp=11111", vga_rgb); failures++; end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (vga_rgb !== 5'b00000) begin $display("FAIL async_rgb got=%b exp=00000", vga_rgb); failures++; end
        checks++; if (active !== 1'b0) begin $display("FAIL async_active got=%b exp=0", active); failures++; end
        checks++; if (done !== 1'b0) begin $display("FAIL async_done got=%b exp=0", done); failures++; end
    endtask

    initial begin
        test_reset();
        test_reveal_win();
        test_hold_win();
        test_stars();
        test_leave();
        test_lose();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
